turbo_output_mux: RTL

TURBO_OUTPUT_MUX -- requirements
Module: turbo_output_mux

---
 rtl/turbo_output_mux_if.sv | 28 ++
 rtl/turbo_output_mux.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/turbo_output_mux_if.sv
// Handshake bundle between the turbo encoder core and the rate-1/3 output mux.
// master drives block control and encoder bits; slave is the mux itself.
interface turbo_output_mux_if;
  logic        start;
  logic [12:0] k_len;
  logic        in_valid;
  logic        xk1;
  logic        zk1;
  logic        xk2;
  logic        zk2;
  logic        d0;
  logic        d1;
  logic        d2;
  logic        out_valid;
  logic        out_last;
  logic        busy;
  logic        err;

  modport master (
    output start, k_len, in_valid, xk1, zk1, xk2, zk2,
    input  d0, d1, d2, out_valid, out_last, busy, err
  );

  modport slave (
    input  start, k_len, in_valid, xk1, zk1, xk2, zk2,
    output d0, d1, d2, out_valid, out_last, busy, err
  );
endinterface

// File: rtl/turbo_output_mux.sv
// Turbo encoder output mux: forwards K systematic/parity beats, collects the
// 12 trellis-termination bits, then emits them as four rate-1/3 tail beats.
module turbo_output_mux (
  input logic               clk,
  input logic               aclr,
  turbo_output_mux_if.slave bus
);

  localparam logic [12:0] K_MIN = 13'd40;
  localparam logic [12:0] K_MAX = 13'd6144;

  typedef enum logic [1:0] {IDLE, DATA, TAIL, EMIT} state_t;

  // Termination bits, indexed by tail beat j = 0..2.
  typedef struct packed {
    logic [2:0] zp;
    logic [2:0] xp;
    logic [2:0] z;
    logic [2:0] x;
  } tail_t;

  state_t      state;
  logic [12:0] k_q;
  logic [12:0] beat_cnt;
  logic [1:0]  tail_cnt;
  logic [1:0]  emit_idx;
  tail_t       tail_q;
  logic        d0_q, d1_q, d2_q;
  logic        out_valid_q, out_last_q, busy_q, err_q;
  logic        k_ok;

  assign k_ok = (bus.k_len >= K_MIN) && (bus.k_len <= K_MAX);

  // NOTE: all state uses non-blocking assignments so every branch sees the
  // pre-edge values regardless of statement order inside the block.
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      state       <= IDLE;
      k_q         <= '0;
      beat_cnt    <= '0;
      tail_cnt    <= '0;
      emit_idx    <= '0;
      tail_q      <= '0;
      d0_q        <= 1'b0;
      d1_q        <= 1'b0;
      d2_q        <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      // Output beats last one cycle; idle cycles drive zeros.
      d0_q        <= 1'b0;
      d1_q        <= 1'b0;
      d2_q        <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;

      if (bus.start && state != IDLE) err_q <= 1'b1;

      case (state)
        IDLE: begin
          if (bus.start) begin
            if (k_ok) begin
              state    <= DATA;
              busy_q   <= 1'b1;
              k_q      <= bus.k_len;
              beat_cnt <= '0;
              tail_cnt <= '0;
              err_q    <= 1'b0;
            end else begin
              err_q <= 1'b1;
            end
          end
          if (bus.in_valid) err_q <= 1'b1;
        end

        DATA: begin
          if (bus.in_valid) begin
            d0_q        <= bus.xk1;
            d1_q        <= bus.zk1;
            d2_q        <= bus.zk2;
            out_valid_q <= 1'b1;
            beat_cnt    <= beat_cnt + 13'd1;
            if (beat_cnt == k_q - 13'd1) begin
              state    <= TAIL;
              tail_cnt <= '0;
            end
          end
        end

        TAIL: begin
          if (bus.in_valid) begin
            tail_q.x[tail_cnt]  <= bus.xk1;
            tail_q.z[tail_cnt]  <= bus.zk1;
            tail_q.xp[tail_cnt] <= bus.xk2;
            tail_q.zp[tail_cnt] <= bus.zk2;
            if (tail_cnt == 2'd2) begin
              // Tail beat 0 only needs bits from tail beats 0 and 1.
              state       <= EMIT;
              emit_idx    <= 2'd1;
              d0_q        <= tail_q.x[0];
              d1_q        <= tail_q.z[0];
              d2_q        <= tail_q.x[1];
              out_valid_q <= 1'b1;
            end else begin
              tail_cnt <= tail_cnt + 2'd1;
            end
          end
        end

        EMIT: begin
          if (bus.in_valid) err_q <= 1'b1;
          emit_idx <= emit_idx + 2'd1;
          case (emit_idx)
            2'd1: begin
              d0_q        <= tail_q.z[1];
              d1_q        <= tail_q.x[2];
              d2_q        <= tail_q.z[2];
              out_valid_q <= 1'b1;
            end
            2'd2: begin
              d0_q        <= tail_q.xp[0];
              d1_q        <= tail_q.zp[0];
              d2_q        <= tail_q.xp[1];
              out_valid_q <= 1'b1;
            end
            2'd3: begin
              d0_q        <= tail_q.zp[1];
              d1_q        <= tail_q.xp[2];
              d2_q        <= tail_q.zp[2];
              out_valid_q <= 1'b1;
              out_last_q  <= 1'b1;
            end
            2'd0: begin
              // Cycle after out_last: drop busy and go idle.
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          endcase
        end
      endcase
    end
  end

  assign bus.d0        = d0_q;
  assign bus.d1        = d1_q;
  assign bus.d2        = d2_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.busy      = busy_q;
  assign bus.err       = err_q;

endmodule
